// File: rtl/viterbi_pkg.sv
// Shared types and default thresholds for the Viterbi BER checker.
package viterbi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    LOCKED
  } ber_state_t;

  localparam int unsigned WinDefault     = 32;
  localparam int unsigned SyncThrDefault = 2;
  localparam int unsigned LossThrDefault = 8;

endpackage

// File: rtl/bit_fifo.sv
// DEPTH x 1 reference-bit FIFO with a combinational head output.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module bit_fifo #(
  parameter int unsigned DEPTH = 64
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic push_i,
  input  logic pop_i,
  input  logic din_i,
  output logic dout_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, rptr_q;
  logic [DEPTH-1:0] mem_q;
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign dout_o  = mem_q[rptr_q[AW-1:0]];

  // A pop in the same cycle frees a slot, so a push into a full FIFO is legal then.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Pointer update; clear flushes the contents by collapsing the pointers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (clr_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (AW + 1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (AW + 1)'(1);
    end
  end

  // Storage needs no reset: the pointers decide what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/viterbi_ber_checker.sv
// Bit-error-rate checker: aligns decoded bits against buffered encoder input
// by slipping, declares lock, then counts compared bits and mismatches.
module viterbi_ber_checker
  import viterbi_pkg::*;
#(
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned WIN      = WinDefault,
  parameter int unsigned SYNC_THR = SyncThrDefault,
  parameter int unsigned LOSS_THR = LossThrDefault,
  parameter int unsigned CW       = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          ref_valid_i,
  input  logic          ref_bit_i,
  input  logic          dec_valid_i,
  input  logic          dec_bit_i,
  output logic          locked_o,
  output logic          err_o,
  output logic [CW-1:0] bit_ct_o,
  output logic [CW-1:0] err_ct_o,
  output logic [7:0]    slip_ct_o,
  output logic          ovf_o,
  output logic          unf_o
);

  localparam int unsigned WBW = $clog2(WIN + 1);

  ber_state_t     state_q;
  logic           slip_pend_q;
  logic [WBW-1:0] win_bits_q, win_errs_q;

  logic           fifo_full, fifo_empty, head;
  logic           active, pop, accept, mism, win_end;
  logic [WBW-1:0] bits_nxt, errs_nxt;

  // Decoded bits are ignored until the first reference bit has been accepted.
  assign active   = (state_q != IDLE);
  assign pop      = active & dec_valid_i & ~slip_pend_q & ~fifo_empty;
  assign accept   = ref_valid_i & (~fifo_full | pop);
  assign mism     = head ^ dec_bit_i;
  assign bits_nxt = win_bits_q + WBW'(1);
  assign errs_nxt = win_errs_q + WBW'(mism);
  assign win_end  = pop && (bits_nxt == WBW'(WIN));

  bit_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .rst_ni (rst),
    .clr_i  (clr_i),
    .push_i (accept),
    .pop_i  (pop),
    .din_i  (ref_bit_i),
    .dout_o (head),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  // Alignment FSM together with window bookkeeping and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      slip_pend_q <= 1'b0;
      win_bits_q  <= '0;
      win_errs_q  <= '0;
      locked_o    <= 1'b0;
      err_o       <= 1'b0;
      bit_ct_o    <= '0;
      err_ct_o    <= '0;
      slip_ct_o   <= '0;
      ovf_o       <= 1'b0;
      unf_o       <= 1'b0;
    end else if (clr_i) begin
      state_q     <= IDLE;
      slip_pend_q <= 1'b0;
      win_bits_q  <= '0;
      win_errs_q  <= '0;
      locked_o    <= 1'b0;
      err_o       <= 1'b0;
      bit_ct_o    <= '0;
      err_ct_o    <= '0;
      slip_ct_o   <= '0;
      ovf_o       <= 1'b0;
      unf_o       <= 1'b0;
    end else begin
      err_o <= 1'b0;
      if (ref_valid_i && !accept) ovf_o <= 1'b1;
      if (active && dec_valid_i && !slip_pend_q && fifo_empty) unf_o <= 1'b1;
      // The slipped bit is swallowed, growing the reference delay by one.
      if (active && dec_valid_i && slip_pend_q) slip_pend_q <= 1'b0;

      if (pop) begin
        win_bits_q <= win_end ? '0 : bits_nxt;
        win_errs_q <= win_end ? '0 : errs_nxt;
      end

      unique case (state_q)
        IDLE: begin
          if (accept) state_q <= SYNC;
        end
        SYNC: begin
          if (win_end) begin
            if (errs_nxt <= WBW'(SYNC_THR)) begin
              state_q  <= LOCKED;
              locked_o <= 1'b1;
            end else begin
              slip_pend_q <= 1'b1;
              if (slip_ct_o != 8'hff) slip_ct_o <= slip_ct_o + 8'd1;
            end
          end
        end
        LOCKED: begin
          if (pop) begin
            if (bit_ct_o != '1) bit_ct_o <= bit_ct_o + CW'(1);
            if (mism) begin
              err_o <= 1'b1;
              if (err_ct_o != '1) err_ct_o <= err_ct_o + CW'(1);
            end
          end
          if (win_end && (errs_nxt > WBW'(LOSS_THR))) begin
            state_q  <= SYNC;
            locked_o <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_viterbi_ber_checker.sv
// Bench for viterbi_ber_checker: a queue-based reference model predicts every
// registered output per cycle; scenario totals are checked against fixed values.
module tb_viterbi_ber_checker;

  localparam int unsigned DEPTH    = 64;
  localparam int unsigned WIN      = 32;
  localparam int unsigned SYNC_THR = 2;
  localparam int unsigned LOSS_THR = 8;
  localparam int unsigned CW       = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clr_i = 1'b0;
  logic          ref_valid_i = 1'b0;
  logic          ref_bit_i = 1'b0;
  logic          dec_valid_i = 1'b0;
  logic          dec_bit_i = 1'b0;
  logic          locked_o, err_o, ovf_o, unf_o;
  logic [CW-1:0] bit_ct_o, err_ct_o;
  logic [7:0]    slip_ct_o;

  always #5 clk = ~clk;

  viterbi_ber_checker #(
    .DEPTH   (DEPTH),
    .WIN     (WIN),
    .SYNC_THR(SYNC_THR),
    .LOSS_THR(LOSS_THR),
    .CW      (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (clr_i),
    .ref_valid_i(ref_valid_i),
    .ref_bit_i  (ref_bit_i),
    .dec_valid_i(dec_valid_i),
    .dec_bit_i  (dec_bit_i),
    .locked_o   (locked_o),
    .err_o      (err_o),
    .bit_ct_o   (bit_ct_o),
    .err_ct_o   (err_ct_o),
    .slip_ct_o  (slip_ct_o),
    .ovf_o      (ovf_o),
    .unf_o      (unf_o)
  );

  typedef struct packed {
    logic          locked;
    logic          err;
    logic [CW-1:0] bit_ct;
    logic [CW-1:0] err_ct;
    logic [7:0]    slip_ct;
    logic          ovf;
    logic          unf;
  } exp_t;

  exp_t exp_q[$];
  exp_t m;
  bit   mfifo[$];
  int   mstate;  // 0 idle, 1 sync, 2 locked
  bit   mslip;
  int   mwb, mwe, m_pops;

  int n_cmp = 0;
  int n_bad = 0;
  int err_pulses;
  int lock_cmp;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m = '0;
    mfifo.delete();
    mstate = 0;
    mslip = 1'b0;
    mwb = 0;
    mwe = 0;
  endtask

  task automatic model_step(input bit rv, input bit rb, input bit dv, input bit db, input bit c);
    bit pop, acc, head, mis;
    if (c) begin
      model_reset();
      return;
    end
    m.err = 1'b0;
    pop  = (mstate != 0) && dv && !mslip && (mfifo.size() > 0);
    head = pop ? mfifo[0] : 1'b0;
    acc  = rv && ((mfifo.size() < DEPTH) || pop);
    if (rv && !acc) m.ovf = 1'b1;
    if ((mstate != 0) && dv && !mslip && (mfifo.size() == 0)) m.unf = 1'b1;
    if ((mstate != 0) && dv && mslip) mslip = 1'b0;
    if (pop) begin
      void'(mfifo.pop_front());
      m_pops++;
      mis = head ^ db;
      mwb = mwb + 1;
      mwe = mwe + int'(mis);
      if (mstate == 2) begin
        if (m.bit_ct != '1) m.bit_ct = m.bit_ct + 1;
        if (mis) begin
          m.err = 1'b1;
          if (m.err_ct != '1) m.err_ct = m.err_ct + 1;
        end
      end
      if (mwb == WIN) begin
        if (mstate == 1) begin
          if (mwe <= SYNC_THR) begin
            mstate = 2;
            m.locked = 1'b1;
          end else begin
            mslip = 1'b1;
            if (m.slip_ct != 8'hff) m.slip_ct = m.slip_ct + 1;
          end
        end else if (mwe > LOSS_THR) begin
          mstate = 1;
          m.locked = 1'b0;
        end
        mwb = 0;
        mwe = 0;
      end
    end
    if (acc) begin
      mfifo.push_back(rb);
      if (mstate == 0) mstate = 1;
    end
  endtask

  // Drive one cycle, queue the prediction, then compare just after the edge.
  task automatic step(input bit rv, input bit rb, input bit dv, input bit db, input bit c);
    exp_t e;
    ref_valid_i = rv;
    ref_bit_i   = rb;
    dec_valid_i = dv;
    dec_bit_i   = db;
    clr_i       = c;
    model_step(rv, rb, dv, db, c);
    exp_q.push_back(m);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_val("locked", locked_o, e.locked);
    check_val("err", err_o, e.err);
    check_val("bit_ct", bit_ct_o, e.bit_ct);
    check_val("err_ct", err_ct_o, e.err_ct);
    check_val("slip_ct", slip_ct_o, e.slip_ct);
    check_val("ovf", ovf_o, e.ovf);
    check_val("unf", unf_o, e.unf);
    if (err_o) err_pulses++;
    if (locked_o && lock_cmp < 0) lock_cmp = m_pops;
  endtask

  task automatic do_clr();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    m_pops = 0;
    err_pulses = 0;
    lock_cmp = -1;
  endtask

  // dec stream is the ref stream lat cycles later; the first lat-1 decoded bits are junk.
  task automatic run_stream(input int nbits, input int lat, input int nsteps,
                            input int flip_per, input bit inv);
    bit hist[$];
    int since_lock;
    bit rv, rb, dv, db;
    since_lock = 0;
    for (int t = 0; t < nsteps; t++) begin
      rv = (t < nbits);
      rb = 1'($urandom_range(0, 1));
      if (rv) hist.push_back(rb);
      dv = (t >= 1) && (t < nbits + lat);
      db = 1'b0;
      if (dv) begin
        if (t >= lat) db = hist[t-lat];
        else db = 1'($urandom_range(0, 1));
        if (m.locked) begin
          if (inv) db = ~db;
          if (flip_per > 0 && (since_lock % flip_per) == flip_per - 1) db = ~db;
          since_lock++;
        end
      end
      step(rv, rb, dv, db, 1'b0);
    end
  endtask

  initial begin
    model_reset();
    m_pops = 0;
    err_pulses = 0;
    lock_cmp = -1;
    #12;
    check_val("reset_locked", locked_o, 0);
    check_val("reset_bit_ct", bit_ct_o, 0);
    check_val("reset_slip_ct", slip_ct_o, 0);
    check_val("reset_flags", {ovf_o, unf_o, err_o}, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Minimal-latency loopback
    do_clr();
    run_stream(100, 1, 101, 0, 1'b0);
    check_val("lb_lock_cmp", lock_cmp, 32);
    check_val("lb_bit_ct", bit_ct_o, 68);
    check_val("lb_err_ct", err_ct_o, 0);
    check_val("lb_slip_ct", slip_ct_o, 0);

    // Five extra beats of latency need five slips
    do_clr();
    run_stream(260, 6, 265, 0, 1'b0);
    check_val("d5_slip_ct", slip_ct_o, 5);
    check_val("d5_locked", locked_o, 1);
    check_val("d5_err_ct", err_ct_o, 0);

    // Two errors per window keeps lock
    do_clr();
    run_stream(288, 1, 289, 16, 1'b0);
    check_val("flip_err_ct", err_ct_o, 16);
    check_val("flip_bit_ct", bit_ct_o, 256);
    check_val("flip_pulses", err_pulses, 16);
    check_val("flip_locked", locked_o, 1);

    // Inverted stream drops lock after one window
    do_clr();
    run_stream(64, 1, 65, 0, 1'b1);
    check_val("inv_locked", locked_o, 0);
    check_val("inv_err_ct", err_ct_o, 32);
    check_val("inv_bit_ct", bit_ct_o, 32);

    // Overflow on the 65th push
    do_clr();
    for (int i = 0; i < 65; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
    check_val("ovf_set", ovf_o, 1);

    // Push while full is legal when a pop happens in the same cycle
    do_clr();
    for (int i = 0; i < 64; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check_val("full_pushpop_ovf", ovf_o, 0);

    // Underflow: decoded bit with nothing buffered
    do_clr();
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_val("unf_set", unf_o, 1);
    check_val("unf_bit_ct", bit_ct_o, 0);
    check_val("unf_err_ct", err_ct_o, 0);

    // Reset mid-window after one slip and ten compares
    do_clr();
    run_stream(44, 3, 44, 0, 1'b0);
    check_val("pre_rst_slip", slip_ct_o, 1);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_val("rst_locked", locked_o, 0);
    check_val("rst_slip_ct", slip_ct_o, 0);
    check_val("rst_counts", {bit_ct_o, err_ct_o}, 0);
    check_val("rst_flags", {ovf_o, unf_o, err_o}, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_pops = 0;
    lock_cmp = -1;
    run_stream(100, 1, 101, 0, 1'b0);
    check_val("post_rst_lock_cmp", lock_cmp, 32);
    check_val("post_rst_bit_ct", bit_ct_o, 68);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
